// File: rtl/argon_sequencer.sv
// Fetch/decode/execute control FSM for the Argon datapath: fetches 24-bit words over req/ack
// and drives every datapath control for exactly one EXEC cycle per instruction.
module argon_sequencer #(
    parameter int          PC_WIDTH = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [23:0]         i_imem_data,
    input  logic                i_flag_zero,
    output logic                o_write_en,
    output logic [3:0]          o_selectA,
    output logic [3:0]          o_selectB,
    output logic [3:0]          o_selectW,
    output logic [3:0]          o_alu_op,
    output logic                o_use_immediate,
    output logic                o_write_to_regfile,
    output logic [15:0]         o_imm,
    output logic                o_halt,
    output logic                o_illegal,
    output logic [2:0]          o_dbg_state
);

    // imem handshake: o_imem_req rises with o_imem_addr and both hold until the cycle
    // i_imem_ack is high (ack may arrive in the first req cycle); the word is taken on that edge.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_FETCH_IMM = 3'd2,
        S_EXEC      = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam logic [3:0] C_NOP    = 4'h0;
    localparam logic [3:0] C_ALU_RR = 4'h1;
    localparam logic [3:0] C_ALU_RI = 4'h2;
    localparam logic [3:0] C_LDI    = 4'h3;
    localparam logic [3:0] C_JMP    = 4'h4;
    localparam logic [3:0] C_JZ     = 4'h5;
    localparam logic [3:0] C_HALT   = 4'hF;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [23:0]         ir;
    logic [15:0]         imm_q;
    logic                z_q;

    logic [3:0]          ir_class;
    logic [3:0]          fetch_class;
    logic                fetch_needs_imm;
    logic [PC_WIDTH-1:0] jump_target;

    assign ir_class        = ir[23:20];
    assign fetch_class     = i_imem_data[23:20];
    assign fetch_needs_imm = (fetch_class == C_ALU_RI) || (fetch_class == C_LDI) ||
                             (fetch_class == C_JMP)    || (fetch_class == C_JZ);
    assign jump_target     = PC_WIDTH'(imm_q);

    assign o_imem_addr = pc;
    assign o_imm       = imm_q;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
            pc    <= PC_WIDTH'(RESET_PC);
            ir    <= '0;
            imm_q <= '0;
            z_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: begin
                    if (i_imem_ack) begin
                        ir <= i_imem_data;
                        pc <= pc + PC_WIDTH'(1);
                    end
                end
                S_FETCH_IMM: begin
                    if (i_imem_ack) begin
                        imm_q <= i_imem_data[15:0];
                        pc    <= pc + PC_WIDTH'(1);
                    end
                end
                S_EXEC: begin
                    case (ir_class)
                        C_ALU_RR, C_ALU_RI: z_q <= i_flag_zero;
                        C_JMP:              pc  <= jump_target;
                        C_JZ:               if (z_q) pc <= jump_target;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Controls are decoded from IR only in EXEC, so everything else reads as 0 and halted.
    always_comb begin
        state_next         = state;
        o_imem_req         = 1'b0;
        o_write_en         = 1'b0;
        o_selectA          = 4'd0;
        o_selectB          = 4'd0;
        o_selectW          = 4'd0;
        o_alu_op           = 4'd0;
        o_use_immediate    = 1'b0;
        o_write_to_regfile = 1'b0;
        o_halt             = 1'b1;
        o_illegal          = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_run) state_next = S_FETCH;
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) state_next = fetch_needs_imm ? S_FETCH_IMM : S_EXEC;
            end
            S_FETCH_IMM: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) state_next = S_EXEC;
            end
            S_EXEC: begin
                o_halt     = 1'b0;
                state_next = S_FETCH;
                case (ir_class)
                    C_ALU_RR, C_ALU_RI: begin
                        o_selectA       = ir[11:8];
                        o_selectB       = ir[7:4];
                        o_selectW       = ir[15:12];
                        o_alu_op        = ir[19:16];
                        o_use_immediate = (ir_class == C_ALU_RI);
                        o_write_en      = 1'b1;
                    end
                    C_LDI: begin
                        o_selectW          = ir[15:12];
                        o_write_to_regfile = 1'b1;
                        o_write_en         = 1'b1;
                    end
                    C_NOP, C_JMP, C_JZ: ;
                    C_HALT:  state_next = S_HALTED;
                    default: o_illegal  = 1'b1;
                endcase
            end
            S_HALTED: ;
            default:  state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_argon_sequencer.sv
// Directed bench for argon_sequencer: an instruction-memory driver serves each fetch and
// every scenario checks EXEC controls, PC flow and halt/reset behaviour against hand values.
module tb_argon_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_run = 1'b0;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [23:0] i_imem_data = 24'h0;
    logic        i_flag_zero = 1'b0;
    logic        o_write_en;
    logic [3:0]  o_selectA, o_selectB, o_selectW, o_alu_op;
    logic        o_use_immediate, o_write_to_regfile, o_halt, o_illegal;
    logic [15:0] o_imm;
    logic [2:0]  o_dbg_state;

    int total = 0;
    int bad = 0;

    // {write_en, selA, selB, selW, alu_op, use_imm, write_to_regfile, halt, illegal}
    wire [20:0] ctl_bus = {o_write_en, o_selectA, o_selectB, o_selectW, o_alu_op,
                           o_use_immediate, o_write_to_regfile, o_halt, o_illegal};
    localparam logic [20:0] CTL_QUIET = {1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [20:0] CTL_EXNOP = {1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_FIMM = 3'd2,
                           ST_EXEC = 3'd3, ST_HALTED = 3'd4;

    argon_sequencer #(.PC_WIDTH(16), .RESET_PC(0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_flag_zero(i_flag_zero), .o_write_en(o_write_en),
        .o_selectA(o_selectA), .o_selectB(o_selectB), .o_selectW(o_selectW),
        .o_alu_op(o_alu_op), .o_use_immediate(o_use_immediate),
        .o_write_to_regfile(o_write_to_regfile), .o_imm(o_imm),
        .o_halt(o_halt), .o_illegal(o_illegal), .o_dbg_state(o_dbg_state)
    );

    // clock / watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: waits (bounded) for req, checks the address is held for `waits` extra cycles,
    // then acks with `data`. Returns on the negedge after the accepting edge.
    task automatic serve_fetch(input logic [15:0] addr, input logic [23:0] data,
                               input int waits, input string name);
        int n = 0;
        while (o_imem_req !== 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (o_imem_req !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_timeout: req=%b required=1", name, o_imem_req);
        end
        total++;
        if (o_imem_addr !== addr) begin
            bad++;
            $display("FAIL %s_addr: got=%h required=%h", name, o_imem_addr, addr);
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge i_clk);
            total++;
            if ({o_imem_req, o_imem_addr} !== {1'b1, addr}) begin
                bad++;
                $display("FAIL %s_hold%0d: req=%b addr=%h required req=1 addr=%h",
                         name, i, o_imem_req, o_imem_addr, addr);
            end
        end
        i_imem_ack  = 1'b1;
        i_imem_data = data;
        @(negedge i_clk);
        i_imem_ack  = 1'b0;
        i_imem_data = 24'h0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        total++;
        if ({o_imem_req, o_dbg_state, o_imem_addr, o_imm, ctl_bus} !==
            {1'b0, ST_IDLE, 16'h0, 16'h0, CTL_QUIET}) begin
            bad++;
            $display("FAIL reset_outputs: req=%b st=%0d addr=%h imm=%h ctl=%h required 0/0/0/0/%h",
                     o_imem_req, o_dbg_state, o_imem_addr, o_imm, ctl_bus, CTL_QUIET);
        end
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        total++;
        if ({o_imem_req, o_dbg_state, o_halt} !== {1'b0, ST_IDLE, 1'b1}) begin
            bad++;
            $display("FAIL idle_without_run: req=%b st=%0d halt=%b required 0/0/1",
                     o_imem_req, o_dbg_state, o_halt);
        end
    endtask

    task automatic test_ldi();
        i_run = 1'b1;
        serve_fetch(16'h0000, 24'h301000, 0, "ldi_instr");
        total++;
        if (o_dbg_state !== ST_FIMM) begin
            bad++;
            $display("FAIL ldi_to_fetch_imm: st=%0d required=%0d", o_dbg_state, ST_FIMM);
        end
        serve_fetch(16'h0001, 24'h001234, 0, "ldi_imm");
        total++;
        if ({o_dbg_state, o_imem_req, o_imm, o_imem_addr, ctl_bus} !==
            {ST_EXEC, 1'b0, 16'h1234, 16'h0002,
             {1'b1, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}}) begin
            bad++;
            $display("FAIL ldi_exec: st=%0d req=%b imm=%h pc=%h ctl=%h",
                     o_dbg_state, o_imem_req, o_imm, o_imem_addr, ctl_bus);
        end
        @(negedge i_clk);
        total++;
        if ({o_dbg_state, o_imem_req, ctl_bus} !== {ST_FETCH, 1'b1, CTL_QUIET}) begin
            bad++;
            $display("FAIL ldi_after_exec: st=%0d req=%b ctl=%h required st=1 req=1 ctl=%h",
                     o_dbg_state, o_imem_req, ctl_bus, CTL_QUIET);
        end
    endtask

    task automatic test_alu_rr_wait();
        serve_fetch(16'h0002, 24'h123120, 3, "rr_instr");
        total++;
        if ({o_dbg_state, ctl_bus} !==
            {ST_EXEC, {1'b1, 4'd1, 4'd2, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0}}) begin
            bad++;
            $display("FAIL rr_exec: st=%0d ctl=%h", o_dbg_state, ctl_bus);
        end
        i_flag_zero = 1'b1;
        @(negedge i_clk);
        i_flag_zero = 1'b0;
        total++;
        if ({o_write_en, o_dbg_state, o_imem_addr} !== {1'b0, ST_FETCH, 16'h0003}) begin
            bad++;
            $display("FAIL rr_single_write: we=%b st=%0d pc=%h required 0/1/0003",
                     o_write_en, o_dbg_state, o_imem_addr);
        end
    endtask

    task automatic test_jz();
        // Z=1 from the previous ALU_RR: branch taken, upper data bits ignored
        serve_fetch(16'h0003, 24'h500000, 0, "jz1_instr");
        serve_fetch(16'h0004, 24'hFF0040, 0, "jz1_imm");
        total++;
        if ({o_imm, ctl_bus} !== {16'h0040, CTL_EXNOP}) begin
            bad++;
            $display("FAIL jz_taken_exec: imm=%h ctl=%h required 0040/%h", o_imm, ctl_bus, CTL_EXNOP);
        end
        @(negedge i_clk);
        total++;
        if (o_imem_addr !== 16'h0040) begin
            bad++;
            $display("FAIL jz_taken_target: addr=%h required=0040", o_imem_addr);
        end
        // ALU_RR with flag 0 clears Z, then JZ falls through
        serve_fetch(16'h0040, 24'h1A5670, 0, "clrz_instr");
        i_flag_zero = 1'b0;
        @(negedge i_clk);
        serve_fetch(16'h0041, 24'h500000, 0, "jz0_instr");
        serve_fetch(16'h0042, 24'h000010, 0, "jz0_imm");
        @(negedge i_clk);
        total++;
        if (o_imem_addr !== 16'h0043) begin
            bad++;
            $display("FAIL jz_not_taken: addr=%h required=0043", o_imem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        serve_fetch(16'h0043, 24'h400000, 0, "jmp_instr");
        serve_fetch(16'h0044, 24'h00FFFF, 0, "jmp_imm");
        @(negedge i_clk);
        total++;
        if (o_imem_addr !== 16'hFFFF) begin
            bad++;
            $display("FAIL jmp_target: addr=%h required=ffff", o_imem_addr);
        end
        serve_fetch(16'hFFFF, 24'h254310, 0, "ri_instr");
        serve_fetch(16'h0000, 24'h00BEEF, 0, "ri_imm_wrapped");
        total++;
        if ({o_imm, ctl_bus} !==
            {16'hBEEF, {1'b1, 4'd3, 4'd1, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0}}) begin
            bad++;
            $display("FAIL ri_exec: imm=%h ctl=%h", o_imm, ctl_bus);
        end
        @(negedge i_clk);
        total++;
        if (o_imem_addr !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_next_fetch: addr=%h required=0001", o_imem_addr);
        end
    endtask

    task automatic test_illegal();
        serve_fetch(16'h0001, 24'h7AAAA0, 0, "ill_instr");
        total++;
        if ({o_dbg_state, ctl_bus} !==
            {ST_EXEC, {1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}}) begin
            bad++;
            $display("FAIL illegal_exec: st=%0d ctl=%h", o_dbg_state, ctl_bus);
        end
        @(negedge i_clk);
        total++;
        if ({o_illegal, o_write_en, o_imem_addr} !== {1'b0, 1'b0, 16'h0002}) begin
            bad++;
            $display("FAIL illegal_pulse: ill=%b we=%b pc=%h required 0/0/0002",
                     o_illegal, o_write_en, o_imem_addr);
        end
    endtask

    task automatic test_halt();
        int req_seen = 0;
        serve_fetch(16'h0002, 24'hF00000, 0, "halt_instr");
        total++;
        if ({o_dbg_state, ctl_bus} !== {ST_EXEC, CTL_EXNOP}) begin
            bad++;
            $display("FAIL halt_exec: st=%0d ctl=%h", o_dbg_state, ctl_bus);
        end
        i_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_imem_req !== 1'b0 || o_halt !== 1'b1 || o_dbg_state !== ST_HALTED) req_seen++;
        end
        total++;
        if (req_seen !== 0) begin
            bad++;
            $display("FAIL halted_stays: bad_cycles=%0d required=0", req_seen);
        end
    endtask

    task automatic test_reset_mid_fetch();
        i_reset = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        i_run   = 1'b1;
        serve_fetch(16'h0000, 24'h000000, 0, "nop_instr");
        @(negedge i_clk);
        total++;
        if ({o_dbg_state, o_imem_req, o_imem_addr} !== {ST_FETCH, 1'b1, 16'h0001}) begin
            bad++;
            $display("FAIL pre_reset_fetch: st=%0d req=%b addr=%h required 1/1/0001",
                     o_dbg_state, o_imem_req, o_imem_addr);
        end
        #2 i_reset = 1'b0;
        #1;
        total++;
        if ({o_imem_req, o_dbg_state, o_imem_addr, o_halt} !== {1'b0, ST_IDLE, 16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: req=%b st=%0d addr=%h halt=%b required 0/0/0000/1",
                     o_imem_req, o_dbg_state, o_imem_addr, o_halt);
        end
        @(negedge i_clk);
        i_run       = 1'b0;
        i_reset     = 1'b1;
        i_imem_ack  = 1'b1;
        i_imem_data = 24'h301000;
        @(negedge i_clk);
        i_imem_ack  = 1'b0;
        i_imem_data = 24'h0;
        total++;
        if ({o_dbg_state, o_imem_addr, o_imem_req} !== {ST_IDLE, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL late_ack_ignored: st=%0d addr=%h req=%b required 0/0000/0",
                     o_dbg_state, o_imem_addr, o_imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu_rr_wait();
        test_jz();
        test_pc_wrap();
        test_illegal();
        test_halt();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
